// File: rtl/dlx_decode_pipe.sv
// DLX integer instruction decoder feeding a DEPTH-entry valid/ready output FIFO.
// Optional macro DLX_DECODE_ILLEGAL_COUNT_EN: mark illegal words as class 7 and count them.
module dlx_decode_pipe #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_alu,
  output logic [2:0]       out_class,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [CNT_W-1:0] ill_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;
  localparam logic [2:0] CLS_TRAP   = 3'd5;
`ifdef DLX_DECODE_ILLEGAL_COUNT_EN
  localparam logic [2:0] CLS_ILL    = 3'd7;
`else
  localparam logic [2:0] CLS_ILL    = CLS_ALU;
`endif

  typedef struct packed {
    logic [4:0]  alu;
    logic [2:0]  cls;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } entry_t;

  logic [5:0]  w_op;
  logic [5:0]  w_func;
  logic [4:0]  w_f_rs;
  logic [4:0]  w_f_rt;
  logic [4:0]  w_f_rd;
  logic [31:0] w_sext16;
  logic [31:0] w_zext16;
  logic [31:0] w_sext26;
  logic        w_unused;

  assign w_op     = in_ins[31:26];
  assign w_func   = in_ins[5:0];
  assign w_f_rs   = in_ins[25:21];
  assign w_f_rt   = in_ins[20:16];
  assign w_f_rd   = in_ins[15:11];
  assign w_sext16 = {{16{in_ins[15]}}, in_ins[15:0]};
  assign w_zext16 = {16'h0000, in_ins[15:0]};
  assign w_sext26 = {{6{in_ins[25]}}, in_ins[25:0]};
  assign w_unused = ^in_ins[10:6];

  entry_t w_raw;
  entry_t w_dec;
  logic   w_illegal;

  // Field decode; ALU codes for contiguous opcode/func ranges come from their low bits.
  always_comb begin
    w_raw     = '0;
    w_illegal = 1'b0;
    case (w_op)
      6'h00: begin
        w_raw.rs1 = w_f_rs;
        w_raw.rs2 = w_f_rt;
        w_raw.rd  = w_f_rd;
        case (w_func)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26:
            w_raw.alu = {2'b00, w_func[2:0]};
          6'h04: w_raw.alu = 5'd7;
          6'h06: w_raw.alu = 5'd8;
          6'h07: w_raw.alu = 5'd9;
          6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D:
            w_raw.alu = 5'd10 + {2'b00, w_func[2:0]};
          default: w_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        w_raw.alu = {2'b00, w_op[2:0]};
        w_raw.rs1 = w_f_rs;
        w_raw.rd  = w_f_rt;
        if ((w_op == 6'h08) || (w_op == 6'h0A)) begin
          w_raw.imm = w_sext16;
        end else begin
          w_raw.imm = w_zext16;
        end
      end
      6'h0F: begin
        w_raw.alu = 5'd16;
        w_raw.rs1 = w_f_rs;
        w_raw.rd  = w_f_rt;
        w_raw.imm = {in_ins[15:0], 16'h0000};
      end
      6'h14, 6'h16, 6'h17: begin
        w_raw.alu = (w_op == 6'h14) ? 5'd7 : ((w_op == 6'h16) ? 5'd8 : 5'd9);
        w_raw.rs1 = w_f_rs;
        w_raw.rd  = w_f_rt;
        w_raw.imm = w_sext16;
      end
      6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin
        w_raw.alu = 5'd10 + {2'b00, w_op[2:0]};
        w_raw.rs1 = w_f_rs;
        w_raw.rd  = w_f_rt;
        w_raw.imm = w_sext16;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        w_raw.cls = CLS_LOAD;
        w_raw.rs1 = w_f_rs;
        w_raw.rd  = w_f_rt;
        w_raw.imm = w_sext16;
      end
      6'h28, 6'h29, 6'h2B: begin
        w_raw.cls = CLS_STORE;
        w_raw.rs1 = w_f_rs;
        w_raw.rs2 = w_f_rt;
        w_raw.imm = w_sext16;
      end
      6'h04, 6'h05: begin
        w_raw.cls = CLS_BRANCH;
        w_raw.rs1 = w_f_rs;
        w_raw.imm = w_sext16;
      end
      6'h02, 6'h03: begin
        w_raw.cls = CLS_JUMP;
        w_raw.rd  = w_op[0] ? 5'd31 : 5'd0;
        w_raw.imm = w_sext26;
      end
      6'h12, 6'h13: begin
        w_raw.cls = CLS_JUMP;
        w_raw.rs1 = w_f_rs;
        w_raw.rd  = w_op[0] ? 5'd31 : 5'd0;
        w_raw.imm = w_sext16;
      end
      6'h10, 6'h11: begin
        w_raw.cls = CLS_TRAP;
        w_raw.rs1 = w_f_rs;
        w_raw.rd  = w_f_rt;
        w_raw.imm = w_sext16;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Illegal words collapse to an all-zero entry carrying only the illegal class.
  always_comb begin
    if (w_illegal) begin
      w_dec     = '0;
      w_dec.cls = CLS_ILL;
    end else begin
      w_dec = w_raw;
    end
  end

  entry_t             r_mem [DEPTH];
  entry_t             r_head;
  entry_t             w_head_nxt;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   w_rd_ptr_nxt;
  logic [OCC_W-1:0]   r_count;
  logic [OCC_W-1:0]   w_cnt_nxt;
  logic [OCC_W-1:0]   w_left;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               w_push;
  logic               w_pop;

  assign w_push       = in_valid & r_in_ready & ~flush;
  assign w_pop        = r_out_valid & out_ready & ~flush;
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
  assign w_left       = r_count - OCC_W'(w_pop);

  // Next occupancy.
  always_comb begin
    w_cnt_nxt = r_count;
    if (flush) begin
      w_cnt_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_cnt_nxt = r_count + OCC_W'(1);
        2'b01:   w_cnt_nxt = r_count - OCC_W'(1);
        default: w_cnt_nxt = r_count;
      endcase
    end
  end

  // Next head: a fresh decode bypasses storage only when it lands in an otherwise empty FIFO.
  always_comb begin
    w_head_nxt = r_head;
    if (flush) begin
      w_head_nxt = r_head;
    end else if (w_left == '0) begin
      if (w_push) begin
        w_head_nxt = w_dec;
      end else begin
        w_head_nxt = r_head;
      end
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_dec;
    end
  end

  // FIFO control, flags and the head register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_head      <= '0;
    end else begin
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_rd_ptr <= w_rd_ptr_nxt;
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      end
      r_count     <= w_cnt_nxt;
      r_out_valid <= (w_cnt_nxt != '0);
      r_in_ready  <= (w_cnt_nxt != OCC_W'(DEPTH));
      r_head      <= w_head_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_alu   = r_head.alu;
  assign out_class = r_head.cls;
  assign out_rs1   = r_head.rs1;
  assign out_rs2   = r_head.rs2;
  assign out_rd    = r_head.rd;
  assign out_imm   = r_head.imm;

`ifdef DLX_DECODE_ILLEGAL_COUNT_EN
  logic [CNT_W-1:0] r_ill_cnt;

  // Saturating count of pushed illegal entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ill_cnt <= '0;
    end else if (w_push && w_illegal && (r_ill_cnt != {CNT_W{1'b1}})) begin
      r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign ill_count = r_ill_cnt;
`else
  assign ill_count = '0;
`endif

endmodule

// File: tb/tb_dlx_decode_pipe.sv
// Directed, table-driven bench for dlx_decode_pipe (DEPTH=2, CNT_W=8).
module tb_dlx_decode_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_ins;
  logic [4:0]  out_alu, out_rs1, out_rs2, out_rd;
  logic [2:0]  out_class;
  logic [31:0] out_imm;
  logic [7:0]  ill_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DLX_DECODE_ILLEGAL_COUNT_EN
  localparam logic [2:0] EXP_ILL = 3'd7;
`else
  localparam logic [2:0] EXP_ILL = 3'd0;
`endif

  dlx_decode_pipe #(.DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_class(out_class),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [63:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [63:0] pk(input logic [4:0] alu, input logic [2:0] cls,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [31:0] imm);
    return {9'd0, alu, cls, rs1, rs2, rd, imm};
  endfunction

  function automatic logic [63:0] head();
    return pk(out_alu, out_class, out_rs1, out_rs2, out_rd, out_imm);
  endfunction

  // ADD rK,r1,r2 used as a tagged stream word
  function automatic logic [31:0] mk_add(input int k);
    logic [31:0] w;
    w = 32'h00220020 | (32'(k) << 11);
    return w;
  endfunction

  function automatic logic [63:0] exp_add(input int k);
    return pk(5'd0, 3'd0, 5'd1, 5'd2, 5'(k), 32'd0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input logic [31:0] ins, input logic [63:0] e);
    vec_t v;
    v.name = n;
    v.ins  = ins;
    v.exp  = e;
    vq.push_back(v);
  endtask

  initial begin
    int exp_q[$];
    int k;
    logic acc, popv;

    add_vec("add",   32'h00221820, pk(5'd0,  3'd0, 5'd1,  5'd2, 5'd3,  32'h00000000));
    add_vec("subui", 32'h2C22FFFF, pk(5'd3,  3'd0, 5'd1,  5'd0, 5'd2,  32'h0000FFFF));
    add_vec("lw",    32'h8C620004, pk(5'd0,  3'd1, 5'd3,  5'd0, 5'd2,  32'h00000004));
    add_vec("sw",    32'hAC85FFF8, pk(5'd0,  3'd2, 5'd4,  5'd5, 5'd0,  32'hFFFFFFF8));
    add_vec("beqz",  32'h10E90010, pk(5'd0,  3'd3, 5'd7,  5'd0, 5'd0,  32'h00000010));
    add_vec("j",     32'h0BFFFFFC, pk(5'd0,  3'd4, 5'd0,  5'd0, 5'd0,  32'hFFFFFFFC));
    add_vec("jal",   32'h0D200100, pk(5'd0,  3'd4, 5'd0,  5'd0, 5'd31, 32'h01200100));
    add_vec("jalr",  32'h4CC00000, pk(5'd0,  3'd4, 5'd6,  5'd0, 5'd31, 32'h00000000));
    add_vec("lhi",   32'h3C08ABCD, pk(5'd16, 3'd0, 5'd0,  5'd0, 5'd8,  32'hABCD0000));
    add_vec("srai",  32'h5D6A0003, pk(5'd9,  3'd0, 5'd11, 5'd0, 5'd10, 32'h00000003));
    add_vec("slt",   32'h0043082A, pk(5'd12, 3'd0, 5'd2,  5'd3, 5'd1,  32'h00000000));
    add_vec("srl",   32'h00853006, pk(5'd8,  3'd0, 5'd4,  5'd5, 5'd6,  32'h00000000));
    add_vec("addi",  32'h2022FFFF, pk(5'd0,  3'd0, 5'd1,  5'd0, 5'd2,  32'hFFFFFFFF));
    add_vec("xori",  32'h38228000, pk(5'd6,  3'd0, 5'd1,  5'd0, 5'd2,  32'h00008000));
    add_vec("sgei",  32'h74228000, pk(5'd15, 3'd0, 5'd1,  5'd0, 5'd2,  32'hFFFF8000));
    add_vec("trap",  32'h44000005, pk(5'd0,  3'd5, 5'd0,  5'd0, 5'd0,  32'h00000005));
    add_vec("ill_r", 32'h00221827, pk(5'd0,  EXP_ILL, 5'd0, 5'd0, 5'd0, 32'h00000000));
    add_vec("ill_op",32'hFC000000, pk(5'd0,  EXP_ILL, 5'd0, 5'd0, 5'd0, 32'h00000000));
    add_vec("ill_fp",32'h04221820, pk(5'd0,  EXP_ILL, 5'd0, 5'd0, 5'd0, 32'h00000000));

    // Reset held two cycles with input valid
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ins = 32'h00221820; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_ill_count", 64'(ill_count), 64'd0);
    check("rst_data",      head(),         64'd0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("rst_nothing_pushed", 64'(out_valid), 64'd0);

    // Streaming table
    out_ready = 1'b1;
    foreach (vq[i]) begin
      in_valid = 1'b1; in_ins = vq[i].ins;
      step();
      check({vq[i].name, "_valid"}, 64'(out_valid), 64'd1);
      check(vq[i].name, head(), vq[i].exp);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_ins = mk_add(20);
    step();
    check("bp_ready_after1", 64'(in_ready), 64'd1);
    check("bp_head_a",       head(), exp_add(20));
    in_ins = mk_add(21);
    step();
    check("bp_ready_full", 64'(in_ready), 64'd0);
    in_ins = mk_add(22);
    step();
    check("bp_third_held", 64'(in_ready), 64'd0);
    step();
    check("bp_head_stable", head(), exp_add(20));
    out_ready = 1'b1;
    step();
    check("bp_drain_b",     head(), exp_add(21));
    check("bp_ready_again", 64'(in_ready), 64'd1);
    step();
    check("bp_drain_c",     head(), exp_add(22));
    in_valid = 1'b0;
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Full push/pop with an ordering scoreboard
    out_ready = 1'b0; in_valid = 1'b1;
    in_ins = mk_add(10); step();
    in_ins = mk_add(11); step();
    exp_q.push_back(10); exp_q.push_back(11);
    check("full_reached", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    k = 12;
    for (int c = 0; c < 4; c++) begin
      in_ins = mk_add(k);
      acc = in_ready; popv = out_valid;
      check("full_valid", 64'(out_valid), 64'd1);
      if (popv) begin
        check("full_order", head(), exp_add(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(k);
        k++;
      end
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("full_extra_entry", 64'(out_valid), 64'd0);
        end else begin
          check("full_drain_order", head(), exp_add(exp_q[0]));
          void'(exp_q.pop_front());
        end
        step();
      end
    end
    check("full_no_loss", 64'(exp_q.size()), 64'd0);
    check("full_empty",   64'(out_valid), 64'd0);

    // Flush with a concurrent input and pop
    out_ready = 1'b0; in_valid = 1'b1;
    in_ins = mk_add(1); step();
    in_ins = mk_add(2); step();
    flush = 1'b1; out_ready = 1'b1; in_ins = mk_add(3);
    step();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready),  64'd1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush_input_dropped", 64'(out_valid), 64'd0);

    // Reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1; in_ins = mk_add(4);
    step();
    reset = 1'b1; in_valid = 1'b0;
    step();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(in_ready),  64'd1);
    reset = 1'b0; out_ready = 1'b1;
    step();
    check("midrst_no_pop", 64'(out_valid), 64'd0);

`ifdef DLX_DECODE_ILLEGAL_COUNT_EN
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_ins = 32'hFC000000;
      step();
      check("ill_class", 64'(out_class), 64'd7);
      check("ill_count", 64'(ill_count), (i + 1 > 255) ? 64'd255 : 64'(i + 1));
    end
    in_valid = 1'b0;
    step();
    check("ill_saturated", 64'(ill_count), 64'd255);
`else
    in_valid = 1'b1; in_ins = 32'hFC000000;
    step();
    check("ill_nop", pk(out_alu, out_class, 5'd0, 5'd0, out_rd, 32'd0),
          pk(5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0));
    check("ill_count_tied", 64'(ill_count), 64'd0);
    in_valid = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
